// File: rtl/scene_pkg.sv
// scene_pkg: shared scene ids, FSM state encodings and fade constants for the
// scene sequencer and its pixel scaler.
package scene_pkg;

  // Brightness level: 0 (black) .. 16 (identity), needs 5 bits.
  localparam int               LVL_W    = 5;
  localparam logic [LVL_W-1:0] FADE_MAX = 5'd16;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    GAME  = 2'd1,
    WIN   = 2'd2,
    LOSE  = 2'd3
  } scene_e;

  typedef enum logic [2:0] {
    S_TITLE    = 3'd0,
    S_GAME     = 3'd1,
    S_WIN      = 3'd2,
    S_LOSE     = 3'd3,
    S_FADE_OUT = 3'd4,
    S_FADE_IN  = 3'd5
  } state_e;

  // Stable state that displays a given scene.
  function automatic state_e stable_state(input scene_e s);
    case (s)
      GAME:    return S_GAME;
      WIN:     return S_WIN;
      LOSE:    return S_LOSE;
      default: return S_TITLE;
    endcase
  endfunction

endpackage

// File: rtl/scene_sequencer_fade_scaler.sv
// fade_scaler: combinational brightness scaler.
// Ports:
//   pix   in  12  {R,G,B} 4 bits each
//   level in  5   brightness 0..16
//   out   out 12  each channel = (c * level) >> 4
module fade_scaler
  import scene_pkg::*;
(
  input  logic [11:0]      pix,
  input  logic [LVL_W-1:0] level,
  output logic [11:0]      out
);

  // 15 * 16 = 240 fits in 8 bits, so level 16 is an exact identity.
  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [7:0] prod;
    assign prod           = {4'd0, pix[4*g +: 4]} * {3'd0, level};
    assign out[4*g +: 4]  = 4'(prod >> 4);
  end

endmodule

// File: rtl/scene_sequencer.sv
// scene_sequencer: title -> game -> win/lose -> title scene controller for the
// VGA path. Muxes the active scene generator onto vga_data and runs a
// frame-synchronous fade-out / fade-in on every scene change.
// Ports:
//   clk, rst_n                 pixel clock, async active-low reset
//   h_cnt, v_cnt, valid        shared VGA timing
//   start_pulse                debounced start button (1 cycle)
//   win_evt, lose_evt          game outcome events (1 cycle)
//   title/game/win/lose_data   12-bit scene pixels
//   vga_data                   registered output pixel (1-cycle latency)
//   scene                      current scene id
//   fading                     high during FADE_OUT / FADE_IN
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int H_LAST           = 639,
  parameter int V_LAST           = 479,
  parameter int FADE_STEP_FRAMES = 2,
  parameter int HOLD_FRAMES      = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        start_pulse,
  input  logic        win_evt,
  input  logic        lose_evt,
  input  logic [11:0] title_data,
  input  logic [11:0] game_data,
  input  logic [11:0] win_data,
  input  logic [11:0] lose_data,
  output logic [11:0] vga_data,
  output logic [1:0]  scene,
  output logic        fading
);

  localparam int STEP_W = $clog2(FADE_STEP_FRAMES + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  state_e            state;
  scene_e            scene_q;
  scene_e            next_scene;
  scene_e            pend;
  logic              pend_vld;
  logic [LVL_W-1:0]  level;
  logic [STEP_W-1:0] step;
  logic [HOLD_W-1:0] hold;
  logic              at_last, at_last_d;
  logic              frame_tick;
  logic [11:0]       src, scaled;

  // Edge-detect the registered end-of-frame flag: one tick per frame even if
  // the counters sit on the last pixel for several cycles.
  assign frame_tick = at_last & ~at_last_d;
  assign scene      = scene_q;

  always_comb begin
    src = title_data;
    case (scene_q)
      GAME:    src = game_data;
      WIN:     src = win_data;
      LOSE:    src = lose_data;
      default: src = title_data;
    endcase
  end

  fade_scaler u_scaler (
    .pix   (src),
    .level (level),
    .out   (scaled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_TITLE;
      scene_q    <= TITLE;
      next_scene <= TITLE;
      pend       <= TITLE;
      pend_vld   <= 1'b0;
      level      <= FADE_MAX;
      step       <= '0;
      hold       <= '0;
      at_last    <= 1'b0;
      at_last_d  <= 1'b0;
      fading     <= 1'b0;
      vga_data   <= 12'h000;
    end else begin
      at_last   <= (h_cnt == 10'(H_LAST)) && (v_cnt == 10'(V_LAST));
      at_last_d <= at_last;
      vga_data  <= valid ? scaled : 12'h000;

      case (state)
        S_TITLE, S_GAME, S_WIN, S_LOSE: begin
          if (frame_tick && pend_vld) begin
            state      <= S_FADE_OUT;
            fading     <= 1'b1;
            next_scene <= pend;
            pend_vld   <= 1'b0;
            step       <= '0;
          end else begin
            // Hold counter saturates so a long stall cannot wrap it.
            if (frame_tick && (state == S_WIN || state == S_LOSE) && hold != HOLD_MAX)
              hold <= hold + 1'b1;
            // Single pending slot: once filled, later events are dropped.
            if (!pend_vld) begin
              case (state)
                S_TITLE: if (start_pulse) begin
                  pend     <= GAME;
                  pend_vld <= 1'b1;
                end
                S_GAME: if (win_evt) begin
                  pend     <= WIN;
                  pend_vld <= 1'b1;
                end else if (lose_evt) begin
                  pend     <= LOSE;
                  pend_vld <= 1'b1;
                end
                default: if (start_pulse || (frame_tick && hold == HOLD_LAST)) begin
                  pend     <= TITLE;
                  pend_vld <= 1'b1;
                end
              endcase
            end
          end
        end

        S_FADE_OUT: if (frame_tick) begin
          if (step == STEP_LAST) begin
            step  <= '0;
            level <= level - 1'b1;
            // Swap the source at black so the change is invisible.
            if (level == LVL_W'(1)) begin
              scene_q <= next_scene;
              state   <= S_FADE_IN;
            end
          end else begin
            step <= step + 1'b1;
          end
        end

        S_FADE_IN: if (frame_tick) begin
          if (step == STEP_LAST) begin
            step  <= '0;
            level <= level + 1'b1;
            if (level == FADE_MAX - 1'b1) begin
              state  <= stable_state(scene_q);
              fading <= 1'b0;
              hold   <= '0;
            end
          end else begin
            step <= step + 1'b1;
          end
        end

        default: begin
          state  <= S_TITLE;
          fading <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer. Frame ticks are produced by parking the
// counters on the last visible pixel for one cycle, so a full fade is short.
module tb_scene_sequencer;

  localparam int H_LAST = 639;
  localparam int V_LAST = 479;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid, start_pulse, win_evt, lose_evt;
  logic [11:0] title_data, game_data, win_data, lose_data;
  logic [11:0] vga_data;
  logic [1:0]  scene;
  logic        fading;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scene_sequencer #(
    .H_LAST           (H_LAST),
    .V_LAST           (V_LAST),
    .FADE_STEP_FRAMES (2),
    .HOLD_FRAMES      (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .valid       (valid),
    .start_pulse (start_pulse),
    .win_evt     (win_evt),
    .lose_evt    (lose_evt),
    .title_data  (title_data),
    .game_data   (game_data),
    .win_data    (win_data),
    .lose_data   (lose_data),
    .vga_data    (vga_data),
    .scene       (scene),
    .fading      (fading)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a negedge, returns on a negedge with the tick fully applied
  // (state updated and the pixel register reloaded at the new level).
  task automatic frame();
    h_cnt = 10'(H_LAST); v_cnt = 10'(V_LAST);
    @(negedge clk);
    h_cnt = 10'd0; v_cnt = 10'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1; @(negedge clk); start_pulse = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; h_cnt = '0; v_cnt = '0; valid = 1'b1;
    start_pulse = 1'b0; win_evt = 1'b0; lose_evt = 1'b0;
    title_data = 12'hABC; game_data = 12'hFFF; win_data = 12'h5A3; lose_data = 12'h3C7;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_vga", 32'(vga_data), 32'h000);
    chk("rst_scene", 32'(scene), 32'd0);
    chk("rst_fading", 32'(fading), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_vga", 32'(vga_data), 32'hABC);

    // Level 16 is identity
    title_data = 12'hF84;
    @(negedge clk);
    chk("lvl16_vga", 32'(vga_data), 32'hF84);

    // Title -> game
    pulse_start();
    chk("start_no_fade_yet", 32'(fading), 32'd0);
    frame();
    chk("start_fading", 32'(fading), 32'd1);
    frames(16);                       // level 8
    chk("lvl8_vga", 32'(vga_data), 32'h742);
    lose_evt = 1'b1; start_pulse = 1'b1; @(negedge clk);
    lose_evt = 1'b0; start_pulse = 1'b0;
    frames(16);                       // level 0, scene swapped
    chk("lvl0_vga", 32'(vga_data), 32'h000);
    chk("mid_scene_game", 32'(scene), 32'd1);
    chk("mid_fading", 32'(fading), 32'd1);
    frames(16);                       // fade-in level 8
    chk("fadein_dim_vga", 32'(vga_data), 32'h777);
    frames(16);                       // level 16
    chk("game_vga", 32'(vga_data), 32'hFFF);
    chk("game_fading", 32'(fading), 32'd0);
    chk("game_scene", 32'(scene), 32'd1);

    // Simultaneous win and lose: win takes priority; later lose ignored
    win_evt = 1'b1; lose_evt = 1'b1; @(negedge clk);
    win_evt = 1'b0; lose_evt = 1'b0;
    chk("win_no_fade_yet", 32'(fading), 32'd0);
    frame();
    chk("win_fading", 32'(fading), 32'd1);
    lose_evt = 1'b1; @(negedge clk); lose_evt = 1'b0;
    frames(32);
    chk("win_mid_scene", 32'(scene), 32'd2);
    frames(32);
    chk("win_scene", 32'(scene), 32'd2);
    chk("win_fading_done", 32'(fading), 32'd0);
    chk("win_vga", 32'(vga_data), 32'h5A3);

    // Auto-return after 3 held frames
    frame();
    chk("hold1", 32'(fading), 32'd0);
    frame();
    chk("hold2", 32'(fading), 32'd0);
    frame();
    chk("hold3", 32'(fading), 32'd0);
    frame();
    chk("hold_fade", 32'(fading), 32'd1);
    frames(32);
    chk("hold_title_scene", 32'(scene), 32'd0);
    frames(32);
    chk("hold_title_fading", 32'(fading), 32'd0);
    chk("hold_title_vga", 32'(vga_data), 32'hF84);

    // Title -> game -> lose, then early return by start at hold tick 1
    pulse_start();
    frames(65);
    chk("g2_scene", 32'(scene), 32'd1);
    lose_evt = 1'b1; @(negedge clk); lose_evt = 1'b0;
    frames(65);
    chk("lose_scene", 32'(scene), 32'd3);
    chk("lose_vga", 32'(vga_data), 32'h3C7);
    frame();
    chk("lose_hold1", 32'(fading), 32'd0);
    pulse_start();
    frame();
    chk("early_fade", 32'(fading), 32'd1);
    frames(32);
    chk("early_scene", 32'(scene), 32'd0);
    frames(32);
    chk("early_done", 32'(fading), 32'd0);

    // Blanking
    valid = 1'b0; @(negedge clk);
    chk("blank_vga", 32'(vga_data), 32'h000);
    valid = 1'b1; @(negedge clk);
    chk("unblank_vga", 32'(vga_data), 32'hF84);

    // Reset in the middle of a fade-out
    pulse_start();
    frame();
    frames(4);                        // level 14
    chk("fo_lvl14_vga", 32'(vga_data), 32'hD73);
    chk("fo_fading", 32'(fading), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_vga", 32'(vga_data), 32'h000);
    chk("midrst_scene", 32'(scene), 32'd0);
    chk("midrst_fading", 32'(fading), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_vga", 32'(vga_data), 32'hF84);
    chk("after_rst_fading", 32'(fading), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
